module_perf_monitor: RTL
========================

MODULE_PERF_MONITOR -- requirements
Module: module_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, giving the number of monitored ap_ctrl channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of every counter and of rd_data (8..64).
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mon_en, input, 1 bit: enables counter updates.
REQ-006 SHALL have port mon_clr, input, 1 bit: synchronous clear of all channels.
REQ-007 SHALL have ports ch_start, ch_ready, ch_done and ch_continue, each input, NUM_CH bits, one bit per channel (ap_start, ap_ready, ap_done, ap_continue).
REQ-008 SHALL have port rd_en, input, 1 bit: read request.
REQ-009 SHALL have port rd_ch, input, 4 bits: channel to read.
REQ-010 SHALL have port rd_sel, input, 3 bits: statistic to read.
REQ-011 SHALL have port rd_valid, output, 1 bit: read data valid.
REQ-012 SHALL have port rd_data, output, CNT_W bits: read data.
REQ-013 SHALL have port rd_err, output, 1 bit: rd_ch is out of range.

Function
REQ-014 SHALL run one FSM per channel with states IDLE, BUSY and WAIT_CONT.
REQ-015 SHALL move IDLE->BUSY on ch_start=1; that cycle counts as latency cycle 1.
REQ-016 SHALL count latency +1 per cycle while BUSY; the cycle ch_done=1 is included.
REQ-017 SHALL, in BUSY with ch_done=1, load last_lat, update min_lat and max_lat, then:
- ch_continue=1: increment inv_cnt; go to BUSY if ch_start=1 (back-to-back, latency restarts at 1), otherwise IDLE.
- ch_continue=0: go to WAIT_CONT.
REQ-018 SHALL, in WAIT_CONT, increment stall_cyc each cycle ch_continue=0; on ch_continue=1, increment inv_cnt and apply the REQ-017 next-state rule.
REQ-019 SHALL increment busy_cyc every cycle the channel is in BUSY or WAIT_CONT.
REQ-020 SHALL treat a ready event as ch_start&ch_ready:
- first event after reset or clear: only restart the interval counter at 1;
- later events: load last_ii with the interval counter, then restart it at 1.
REQ-021 SHALL, with mon_en=0, keep the FSMs tracking state but freeze every counter and statistic update.
REQ-022 SHALL saturate every counter at 2^CNT_W-1 and set a sticky per-channel ovf bit when any counter of that channel saturates.
REQ-023 SHALL, on mon_clr=1, return all FSMs to IDLE and reset all statistics to reset values; mon_clr overrides same-cycle events.
REQ-024 SHALL select statistics by rd_sel: 0 inv_cnt, 1 busy_cyc, 2 last_lat, 3 min_lat, 4 max_lat, 5 last_ii, 6 stall_cyc, 7 status {ovf, state[1:0]} zero-extended (IDLE=0, BUSY=1, WAIT_CONT=2).
REQ-025 SHALL register read results so that rd_valid, rd_data and rd_err appear exactly 1 cycle after rd_en, with rd_valid=0 otherwise.
REQ-026 SHALL return values as they were before any same-cycle update when a read hits a channel being updated.
REQ-027 SHALL, for rd_ch>=NUM_CH, return rd_data=0 with rd_err=1.
REQ-028 SHALL report min_lat=all-ones until the first completion.

Reset
REQ-029 SHALL, while ap_rst_n=0, immediately force all FSMs to IDLE, rd_valid=0, rd_data=0, rd_err=0, min_lat=all-ones, all other statistics and ovf=0.
REQ-030 SHALL discard any in-flight measurement when reset asserts mid-operation, with no partial update.
REQ-031 SHALL resume operation on the first rising edge after ap_rst_n deasserts.

Verification
REQ-032 SHALL cover a single call: ch0 start at cycle 10, done and continue at cycle 19 -> last_lat=10, min=max=10, inv_cnt=1, busy_cyc=10.
REQ-033 SHALL cover back-to-back calls: ch1 latencies 4 and 6 with start held high -> inv_cnt=2, min=4, max=6, no IDLE cycle between calls.
REQ-034 SHALL cover a continue stall: ch2 done with continue low for 3 cycles -> stall_cyc=3, state reads 2 during the stall, inv_cnt increments on the continue cycle.
REQ-035 SHALL cover intervals: ready events at cycles 5, 12 and 20 -> last_ii=7 after the second event and 8 after the third.
REQ-036 SHALL cover saturation: CNT_W=8 with a 300-cycle busy period -> busy_cyc=255, status ovf=1.
REQ-037 SHALL cover invalid read, clear and reset:
- rd_ch=NUM_CH -> rd_err=1, rd_data=0;
- mon_clr while BUSY -> state=0, all statistics at reset values;
- ap_rst_n low for one cycle mid-call -> all outputs 0.

Source files
------------

// File: rtl/module_perf_monitor.sv
// rtl/module_perf_monitor.sv - per-channel ap_ctrl latency, interval and stall monitor
// Each channel runs its own IDLE/BUSY/WAIT_CONT tracker; statistics are read through a registered port.
module module_perf_monitor #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              mon_en,
    input  logic              mon_clr,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_continue,
    input  logic              rd_en,
    input  logic [3:0]        rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, WAIT_CONT = 2'd2} state_t;

    localparam logic [CNT_W-1:0] ONES = '1;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] NEAR = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [4:0]       NCH  = 5'(NUM_CH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ONES) ? v : v + ONE;
    endfunction

    logic [CNT_W-1:0] stat [NUM_CH][8];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           st;
        logic [CNT_W-1:0] lat, ii, inv_cnt, busy_cyc, stall_cyc;
        logic [CNT_W-1:0] last_lat, min_lat, max_lat, last_ii, lat_now;
        logic             ii_seen, ovf;
        logic             in_idle, in_busy, in_wait, complete, finish, launch;
        logic             busy_inc, stall_inc, rdy, ii_inc, ovf_hit;

        assign in_idle   = (st == IDLE);
        assign in_busy   = (st == BUSY);
        assign in_wait   = (st == WAIT_CONT);
        assign complete  = in_busy & ch_done[c];
        assign finish    = (complete | in_wait) & ch_continue[c];
        // A launch from a finishing call makes the finishing cycle latency cycle 1 of the next call.
        assign launch    = (in_idle | finish) & ch_start[c];
        assign busy_inc  = in_busy | in_wait | (in_idle & ch_start[c]);
        assign stall_inc = in_wait & ~ch_continue[c];
        assign rdy       = ch_start[c] & ch_ready[c];
        assign ii_inc    = ii_seen & ~rdy;
        assign lat_now   = sat_inc(lat);
        assign ovf_hit   = (finish & (inv_cnt >= NEAR)) | (busy_inc & (busy_cyc >= NEAR)) |
                           (stall_inc & (stall_cyc >= NEAR)) | (in_busy & (lat >= NEAR)) |
                           (ii_inc & (ii >= NEAR));

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                st <= IDLE;       lat <= '0;       ii <= '0;        ii_seen <= 1'b0;
                inv_cnt <= '0;    busy_cyc <= '0;  stall_cyc <= '0; last_lat <= '0;
                min_lat <= ONES;  max_lat <= '0;   last_ii <= '0;   ovf <= 1'b0;
            end else if (mon_clr) begin
                st <= IDLE;       lat <= '0;       ii <= '0;        ii_seen <= 1'b0;
                inv_cnt <= '0;    busy_cyc <= '0;  stall_cyc <= '0; last_lat <= '0;
                min_lat <= ONES;  max_lat <= '0;   last_ii <= '0;   ovf <= 1'b0;
            end else begin
                if (launch)
                    st <= BUSY;
                else if (finish)
                    st <= IDLE;
                else if (complete)
                    st <= WAIT_CONT;

                if (mon_en) begin
                    if (launch)
                        lat <= ONE;
                    else if (in_busy)
                        lat <= lat_now;
                    if (finish)    inv_cnt   <= sat_inc(inv_cnt);
                    if (busy_inc)  busy_cyc  <= sat_inc(busy_cyc);
                    if (stall_inc) stall_cyc <= sat_inc(stall_cyc);
                    if (complete) begin
                        last_lat <= lat_now;
                        if (lat_now < min_lat) min_lat <= lat_now;
                        if (lat_now > max_lat) max_lat <= lat_now;
                    end
                    if (rdy) begin
                        ii      <= ONE;
                        ii_seen <= 1'b1;
                        if (ii_seen) last_ii <= ii;
                    end else if (ii_inc) begin
                        ii <= sat_inc(ii);
                    end
                    if (ovf_hit) ovf <= 1'b1;
                end
            end
        end

        assign stat[c][0] = inv_cnt;
        assign stat[c][1] = busy_cyc;
        assign stat[c][2] = last_lat;
        assign stat[c][3] = min_lat;
        assign stat[c][4] = max_lat;
        assign stat[c][5] = last_ii;
        assign stat[c][6] = stall_cyc;
        assign stat[c][7] = {{(CNT_W-3){1'b0}}, ovf, st};
    end

    logic [CNT_W-1:0] rd_mux;
    logic             rd_bad;

    assign rd_bad = ({1'b0, rd_ch} >= NCH);

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_ch == 4'(c)) rd_mux = stat[c][rd_sel];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en & rd_bad;
            rd_data  <= (rd_en & ~rd_bad) ? rd_mux : '0;
        end
    end
endmodule
